d_format_decode_queue: RTL and testbench
========================================

# d_format_decode_queue

Buffers decoded D-format instructions between the D-format decoder and the issue stage. Captures one decoded instruction per cycle from the decoder's enable-qualified outputs, stores it in a circular queue, and presents the oldest entry to issue under a valid/ready handshake. The decoder cannot be back-pressured, so the queue raises an early stall to fetch and flags any overflow.

## Interface
- `depth`, 8, number of entries; power of two, ≥4
- `ptrWidth`, 3, log2(`depth`)
- `opcodeWidth`, 6, primary opcode width
- `regWidth`, 5, register address width
- `immWidth`, 64, immediate width as delivered by the decoder
- `clock_i`  in  1  clock; all state changes on its rising edge
- `resetn_i`  in  1  asynchronous active-low reset
- `enable_i`  in  1  decoder output valid (push request)
- `opcode_i`  in  `opcodeWidth`  decoded opcode
- `reg1_i`, `reg2_i`  in  `regWidth`  RT/RS and RA fields
- `reg2ValOrZero_i`  in  1  RA=0 means literal zero
- `imm_i`  in  `immWidth`  extended immediate
- `flush_i`  in  1  discard all entries
- `ready_i`  in  1  issue stage accepts head entry
- `valid_o`  out  1  head entry valid
- `opcode_o`, `reg1_o`, `reg2_o`, `reg2ValOrZero_o`, `imm_o`  out  as inputs  head entry fields
- `count_o`  out  `ptrWidth`+1  occupied entries
- `stall_o`  out  1  fetch must hold
- `overflow_o`  out  1  sticky: a push was dropped

## Operation
- Storage: `depth` × 81-bit entries {opcode, reg1, reg2, reg2ValOrZero, imm}; head pointer, tail pointer (`ptrWidth` bits, wrap modulo `depth`), counter 0..`depth`.
- Push: `enable_i`=1 and (count<`depth` or pop this cycle) → write at tail, tail+1.
- Pop: `valid_o`=1 and `ready_i`=1 → head+1.
- Push+pop same cycle: both happen, count unchanged; legal at full and at count=1.
- Push with count=`depth` and no pop: entry dropped, pointers unchanged, `overflow_o` set; it stays set until reset (flush does not clear it).
- Push at count=0: no bypass; the entry appears on the outputs the next cycle.
- `flush_i`=1: head=tail=0, count=0 next cycle. A push and a pop in the same cycle are both ignored. `overflow_o` is not set by a push dropped due to flush.
- `valid_o` = (count≠0). Data outputs show the head entry. When empty, the data outputs hold the last popped or reset value, and issue must ignore them.
- `stall_o` = (count ≥ `depth`−2). The two spare slots cover the instruction in the decoder register and the one fetch is presenting to the decoder.
- Entries are never modified; ordering strictly FIFO.

## Timing
- Reset (asynchronous assert, synchronous release on next edge): pointers 0, count 0, `valid_o` 0, `stall_o` 0, `overflow_o` 0, all data outputs and storage 0.
- Latency: `enable_i` at edge N → `valid_o`=1 and data after edge N (visible cycle N+1).
- `stall_o`, `valid_o`, `count_o` derive from registered count only; no combinational path from `enable_i`/`ready_i` to any output.
- Throughput 1 push + 1 pop per cycle sustained.
- Reset mid-stream discards all entries immediately. A `ready_i` sampled during reset has no effect.

## Structure
- Shared package: D-format entry struct/width constant (81), opcode/reg width constants, and `depth` default. The decoder and the issue stage use the same definitions.
- One natural sub-module: `decode_queue_ram` (depth×width register array, 1 write port, 1 async read port). Pointer/count control stays in the top.

## Test plan
- Reset with `enable_i`=1, then release. Push addi (op 14, rt 3, ra 0, imm 5, zero=1) → cycle after: `valid_o`=1, `opcode_o`=14, `imm_o`=5, `count_o`=1.
- Eight pushes with `ready_i`=0 → `count_o` reaches 8, `stall_o` goes high at count 6, ninth push dropped, `overflow_o`=1, head still entry 1.
- Full queue, push+pop together for 20 cycles with incrementing imm → count stays 8, imm values pop in order, pointers wrap, no overflow.
- Four pushes then `flush_i` with a simultaneous push and `ready_i`=1 → next cycle `count_o`=0, `valid_o`=0; the flushed push is absent.
- Random push/pop (`ready_i` 50%, `enable_i` gated by `stall_o` with 2-cycle lag) for 10k cycles against a scoreboard → exact order match, `overflow_o` never set.
- Assert `resetn_i` asynchronously mid-stream (count 5) → outputs zero without waiting for a clock edge. After release, the first push is returned correctly.

Source files
------------

// File: rtl/d_format_decode_queue_pkg.sv
// Shared D-format entry definitions for decoder, decode queue and issue.
// Field order matches the decoder output bundle.
package d_format_decode_queue_pkg;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned PTR_W    = 3;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned IMM_W    = 64;
  localparam int unsigned ENTRY_W  =
    OPCODE_W + 2 * REG_W + 1 + IMM_W;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    reg1;
    logic [REG_W-1:0]    reg2;
    logic                reg2ValOrZero;
    logic [IMM_W-1:0]    imm;
  } d_entry_t;

endpackage

// File: rtl/d_format_decode_queue_ram.sv
// Register-array storage for the decode queue.
// One write port, one asynchronous read port.
module decode_queue_ram #(
  parameter int unsigned depth    = 8,
  parameter int unsigned ptrWidth = 3,
  parameter int unsigned width    = 81
) (
  input  logic                clock_i,
  input  logic                resetn_i,
  input  logic                we,
  input  logic [ptrWidth-1:0] waddr,
  input  logic [width-1:0]    wdata,
  input  logic [ptrWidth-1:0] raddr,
  output logic [width-1:0]    rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < int'(depth); i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/d_format_decode_queue.sv
// Circular queue of decoded D-format instructions feeding issue.
// Decoder cannot be back-pressured: early stall plus sticky overflow.
module d_format_decode_queue
  import d_format_decode_queue_pkg::*;
#(
  parameter int unsigned depth       = DEPTH,
  parameter int unsigned ptrWidth    = PTR_W,
  parameter int unsigned opcodeWidth = OPCODE_W,
  parameter int unsigned regWidth    = REG_W,
  parameter int unsigned immWidth    = IMM_W
) (
  input  logic                   clock_i,
  input  logic                   resetn_i,
  input  logic                   enable_i,
  input  logic [opcodeWidth-1:0] opcode_i,
  input  logic [regWidth-1:0]    reg1_i,
  input  logic [regWidth-1:0]    reg2_i,
  input  logic                   reg2ValOrZero_i,
  input  logic [immWidth-1:0]    imm_i,
  input  logic                   flush_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [opcodeWidth-1:0] opcode_o,
  output logic [regWidth-1:0]    reg1_o,
  output logic [regWidth-1:0]    reg2_o,
  output logic                   reg2ValOrZero_o,
  output logic [immWidth-1:0]    imm_o,
  output logic [ptrWidth:0]      count_o,
  output logic                   stall_o,
  output logic                   overflow_o
);

  localparam int unsigned entryW =
    opcodeWidth + 2 * regWidth + 1 + immWidth;
  localparam logic [ptrWidth:0] FULL =
    (ptrWidth + 1)'(depth);
  localparam logic [ptrWidth:0] STALL_AT =
    (ptrWidth + 1)'(depth - 2);

  logic [ptrWidth-1:0] head_q;
  logic [ptrWidth-1:0] tail_q;
  logic [ptrWidth:0]   count_q;
  logic                ovf_q;
  logic [entryW-1:0]   last_q;
  logic [entryW-1:0]   wdata;
  logic [entryW-1:0]   rdata;
  logic [entryW-1:0]   head;
  logic                full;
  logic                push;
  logic                pop;
  logic                drop;

  assign wdata = {opcode_i, reg1_i, reg2_i,
                  reg2ValOrZero_i, imm_i};

  assign full = (count_q == FULL);
  assign pop  = valid_o & ready_i & ~flush_i;
  assign push = enable_i & ~flush_i & (~full | pop);
  assign drop = enable_i & ~flush_i & full & ~pop;

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      if (drop)
        ovf_q <= 1'b1;
      if (flush_i) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push)
          tail_q <= tail_q + 1'b1;
        if (pop) begin
          head_q <= head_q + 1'b1;
          last_q <= rdata;
        end
        if (push && !pop)
          count_q <= count_q + 1'b1;
        else if (pop && !push)
          count_q <= count_q - 1'b1;
      end
    end
  end

  decode_queue_ram #(
    .depth    (depth),
    .ptrWidth (ptrWidth),
    .width    (entryW)
  ) u_ram (
    .clock_i  (clock_i),
    .resetn_i (resetn_i),
    .we       (push),
    .waddr    (tail_q),
    .wdata    (wdata),
    .raddr    (head_q),
    .rdata    (rdata)
  );

  // Empty queue keeps showing the last popped entry.
  assign head = valid_o ? rdata : last_q;

  assign {opcode_o, reg1_o, reg2_o,
          reg2ValOrZero_o, imm_o} = head;

  assign valid_o    = (count_q != '0);
  assign count_o    = count_q;
  assign stall_o    = (count_q >= STALL_AT);
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_d_format_decode_queue.sv
// Randomized bench for d_format_decode_queue against a queue-based
// reference model of the FIFO, stall and overflow rules.
module tb_d_format_decode_queue;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        flush;
  logic        rdy;
  logic [80:0] cur;

  logic        valid;
  logic [5:0]  opcode;
  logic [4:0]  reg1;
  logic [4:0]  reg2;
  logic        zero;
  logic [63:0] imm;
  logic [3:0]  count;
  logic        stall;
  logic        ovf;

  logic [80:0] mq [$];
  bit          movf;
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  d_format_decode_queue dut (
    .clock_i         (clk),
    .resetn_i        (rstn),
    .enable_i        (en),
    .opcode_i        (cur[80:75]),
    .reg1_i          (cur[74:70]),
    .reg2_i          (cur[69:65]),
    .reg2ValOrZero_i (cur[64]),
    .imm_i           (cur[63:0]),
    .flush_i         (flush),
    .ready_i         (rdy),
    .valid_o         (valid),
    .opcode_o        (opcode),
    .reg1_o          (reg1),
    .reg2_o          (reg2),
    .reg2ValOrZero_o (zero),
    .imm_o           (imm),
    .count_o         (count),
    .stall_o         (stall),
    .overflow_o      (ovf)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [80:0] mk(
      input logic [5:0] op, input logic [4:0] r1,
      input logic [4:0] r2, input logic z,
      input logic [63:0] im);
    return {op, r1, r2, z, im};
  endfunction

  function automatic logic [80:0] rnd_entry();
    return mk(6'($urandom), 5'($urandom), 5'($urandom),
              1'($urandom), {$urandom, $urandom});
  endfunction

  task automatic compare_all();
    int sz = mq.size();
    chk("valid", valid, sz != 0);
    chk("count", count, sz);
    chk("stall", stall, sz >= 6);
    chk("overflow", ovf, movf);
    if (sz != 0)
      chk("head", {opcode, reg1, reg2, zero, imm}, mq[0]);
  endtask

  // Model decisions use the state before the edge.
  task automatic tick();
    int sz   = mq.size();
    bit mpop = (sz != 0) && rdy && !flush;
    bit mful = (sz == 8);
    bit mpsh = en && !flush && (!mful || mpop);
    if (rstn && en && !flush && mful && !mpop)
      movf = 1'b1;
    @(posedge clk);
    #1;
    if (!rstn) begin
      mq.delete();
      movf = 1'b0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (mpop) void'(mq.pop_front());
      if (mpsh) mq.push_back(cur);
    end
    compare_all();
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    en    = 1'b1;
    flush = 1'b0;
    rdy   = 1'b0;
    cur   = rnd_entry();
    tick();
    tick();
    rstn = 1'b1;
    en   = 1'b0;
    tick();
  endtask

  int          cnt6_stall;
  bit          s1;
  bit          s2;
  logic [63:0] k;

  initial begin
    rstn  = 1'b0;
    en    = 1'b0;
    flush = 1'b0;
    rdy   = 1'b0;
    cur   = '0;
    movf  = 1'b0;

    do_reset();
    chk("rst_opcode", opcode, 6'd0);
    chk("rst_imm", imm, 64'd0);
    chk("rst_valid", valid, 1'b0);

    // addi
    en  = 1'b1;
    cur = mk(6'd14, 5'd3, 5'd0, 1'b1, 64'd5);
    tick();
    en = 1'b0;
    chk("addi_valid", valid, 1'b1);
    chk("addi_opcode", opcode, 6'd14);
    chk("addi_imm", imm, 64'd5);
    chk("addi_count", count, 4'd1);

    // fill to 8, overflow on ninth
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cur = rnd_entry();
      tick();
      if (count == 4'd6) cnt6_stall = int'(stall);
    end
    chk("stall_at_6", cnt6_stall, 1);
    chk("full_count", count, 4'd8);
    cur = rnd_entry();
    tick();
    en = 1'b0;
    chk("ovf_set", ovf, 1'b1);
    chk("head_kept", opcode, 6'd14);
    chk("head_imm_kept", imm, 64'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("ovf_sticky_flush", ovf, 1'b1);

    // full queue streaming
    do_reset();
    en = 1'b1;
    k  = 64'd100;
    for (int i = 0; i < 8; i++) begin
      cur = mk(6'd14, 5'd1, 5'd2, 1'b0, k);
      k++;
      tick();
    end
    rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("stream_imm", imm, 64'd100 + 64'(i));
      cur = mk(6'd14, 5'd1, 5'd2, 1'b0, k);
      k++;
      tick();
    end
    en  = 1'b0;
    rdy = 1'b0;
    chk("stream_count", count, 4'd8);
    chk("stream_ovf", ovf, 1'b0);

    // flush with concurrent push and pop
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cur = rnd_entry();
      tick();
    end
    flush = 1'b1;
    rdy   = 1'b1;
    cur   = mk(6'd33, 5'd7, 5'd7, 1'b0, 64'hdead);
    tick();
    flush = 1'b0;
    rdy   = 1'b0;
    en    = 1'b0;
    chk("flush_count", count, 4'd0);
    chk("flush_valid", valid, 1'b0);
    en  = 1'b1;
    cur = mk(6'd20, 5'd4, 5'd5, 1'b1, 64'd77);
    tick();
    en = 1'b0;
    chk("post_flush_imm", imm, 64'd77);
    chk("post_flush_count", count, 4'd1);

    // random traffic with lagged stall gating
    do_reset();
    s1 = 1'b0;
    s2 = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      en  = ($urandom_range(0, 3) != 0) && !s2;
      rdy = 1'($urandom);
      cur = rnd_entry();
      tick();
      s2 = s1;
      s1 = stall;
    end
    en  = 1'b0;
    rdy = 1'b0;
    chk("rand_no_ovf", ovf, 1'b0);

    // asynchronous reset mid-stream
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cur = rnd_entry();
      tick();
    end
    en = 1'b0;
    chk("pre_async_count", count, 4'd5);
    #2;
    rstn = 1'b0;
    rdy  = 1'b1;
    #1;
    chk("async_count", count, 4'd0);
    chk("async_valid", valid, 1'b0);
    chk("async_opcode", opcode, 6'd0);
    chk("async_imm", imm, 64'd0);
    tick();
    rdy  = 1'b0;
    rstn = 1'b1;
    en   = 1'b1;
    cur  = mk(6'd14, 5'd9, 5'd8, 1'b0, 64'd42);
    tick();
    en = 1'b0;
    chk("after_async_imm", imm, 64'd42);
    chk("after_async_count", count, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
